// File: rtl/fll_pkg.sv
// Shared constants and FSM state type for the FLL discriminator.
package fll_pkg;

  localparam int unsigned PROMPT_W = 16;
  localparam int unsigned MAG_W    = 18;
  localparam int unsigned PROD_W   = 32;
  localparam int unsigned ACC_W    = 33;

  localparam logic [MAG_W-1:0] MAG_SAT = 18'h3FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL0 = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_MUL3 = 3'd4,
    ST_OUT  = 3'd5
  } fll_state_t;

endpackage

// File: rtl/fll_abs_shift_sat.sv
// Combinational |x| >> OUT_SHIFT with saturation to the 18-bit magnitude,
// plus the sign of x (zero reports non-negative).
module fll_abs_shift_sat
  import fll_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 14
) (
  input  logic signed [ACC_W-1:0] value,
  output logic [MAG_W-1:0]        mag,
  output logic                    neg
);

  logic [ACC_W-1:0] abs_val;
  logic [ACC_W-1:0] shifted;

  // Magnitude, scale and clamp.
  always_comb begin
    neg     = value[ACC_W-1];
    abs_val = neg ? (~value + 1'b1) : value;
    shifted = abs_val >> OUT_SHIFT;
    if (|shifted[ACC_W-1:MAG_W]) begin
      mag = MAG_SAT;
    end else begin
      mag = shifted[MAG_W-1:0];
    end
  end

endmodule

// File: rtl/fll_discriminator.sv
// FLL cross/dot discriminator over consecutive prompt samples, using one
// shared 16x16 signed multiplier. Define FLL_DISC_DOT_EN to also compute
// the dot product (adds two multiply states, latency 5 instead of 3).
module fll_discriminator
  import fll_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [PROMPT_W-1:0] i_prompt,
  input  logic signed [PROMPT_W-1:0] q_prompt,
  output logic [MAG_W-1:0]           cross_mag,
  output logic                       cross_neg,
  output logic [MAG_W-1:0]           dot_mag,
  output logic                       dot_neg,
  output logic                       out_valid,
  output logic                       overrun
);

  fll_state_t state;
  logic       hist_valid;

  logic signed [PROMPT_W-1:0] i_prev, q_prev;
  logic signed [PROMPT_W-1:0] i_cur,  q_cur;
  logic signed [PROMPT_W-1:0] op_a,   op_b;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_cross;

  logic [MAG_W-1:0] cross_mag_c;
  logic             cross_neg_c;

  // Operand routing for the shared multiplier, one product per MUL state.
  always_comb begin
    op_a = i_prev;
    op_b = q_cur;
    case (state)
      ST_MUL1: begin
        op_a = i_cur;
        op_b = q_prev;
      end
`ifdef FLL_DISC_DOT_EN
      ST_MUL2: begin
        op_a = i_prev;
        op_b = i_cur;
      end
      ST_MUL3: begin
        op_a = q_prev;
        op_b = q_cur;
      end
`endif
      default: ;
    endcase
  end

  assign prod     = op_a * op_b;
  assign prod_ext = {prod[PROD_W-1], prod};

  fll_abs_shift_sat #(.OUT_SHIFT(OUT_SHIFT)) u_cross_sat (
    .value (acc_cross),
    .mag   (cross_mag_c),
    .neg   (cross_neg_c)
  );

`ifdef FLL_DISC_DOT_EN
  logic signed [ACC_W-1:0] acc_dot;
  logic [MAG_W-1:0]        dot_mag_c;
  logic                    dot_neg_c;

  fll_abs_shift_sat #(.OUT_SHIFT(OUT_SHIFT)) u_dot_sat (
    .value (acc_dot),
    .mag   (dot_mag_c),
    .neg   (dot_neg_c)
  );

  // Dot accumulator and its output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_dot <= '0;
      dot_mag <= '0;
      dot_neg <= 1'b0;
    end else begin
      case (state)
        ST_MUL2: acc_dot <= prod_ext;
        ST_MUL3: acc_dot <= acc_dot + prod_ext;
        ST_OUT: begin
          dot_mag <= dot_mag_c;
          dot_neg <= dot_neg_c;
        end
        default: ;
      endcase
    end
  end
`else
  assign dot_mag = '0;
  assign dot_neg = 1'b0;
`endif

  // Sequencer: history capture, cross accumulation, output and overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hist_valid <= 1'b0;
      i_prev     <= '0;
      q_prev     <= '0;
      i_cur      <= '0;
      q_cur      <= '0;
      acc_cross  <= '0;
      cross_mag  <= '0;
      cross_neg  <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= in_valid && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!hist_valid) begin
              i_prev     <= i_prompt;
              q_prev     <= q_prompt;
              hist_valid <= 1'b1;
            end else begin
              i_cur <= i_prompt;
              q_cur <= q_prompt;
              state <= ST_MUL0;
            end
          end
        end
        ST_MUL0: begin
          acc_cross <= prod_ext;
          state     <= ST_MUL1;
        end
        ST_MUL1: begin
          acc_cross <= acc_cross - prod_ext;
`ifdef FLL_DISC_DOT_EN
          state     <= ST_MUL2;
`else
          state     <= ST_OUT;
`endif
        end
`ifdef FLL_DISC_DOT_EN
        ST_MUL2: state <= ST_MUL3;
        ST_MUL3: state <= ST_OUT;
`endif
        ST_OUT: begin
          cross_mag <= cross_mag_c;
          cross_neg <= cross_neg_c;
          out_valid <= 1'b1;
          i_prev    <= i_cur;
          q_prev    <= q_cur;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fll_discriminator.md
FLL_DISCRIMINATOR -- requirements
Module: fll_discriminator

Interface
REQ-001 Parameter OUT_SHIFT, default 14, is the right-shift applied to the 32-bit discriminator magnitude before the 18-bit output.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  one-cycle strobe: i_prompt/q_prompt hold a completed prompt accumulation.
REQ-005 i_prompt  input  16  signed prompt in-phase accumulation.
REQ-006 q_prompt  input  16  signed prompt quadrature accumulation.
REQ-007 cross_mag  output  18  |cross| >> OUT_SHIFT, saturated; drives the FLL leading-one priority encoder.
REQ-008 cross_neg  output  1  sign of cross (1 = negative).
REQ-009 dot_mag  output  18  |dot| >> OUT_SHIFT, saturated (DOT_EN builds only).
REQ-010 dot_neg  output  1  sign of dot (DOT_EN builds only).
REQ-011 out_valid  output  1  one-cycle strobe: all magnitude/sign outputs updated this cycle.
REQ-012 overrun  output  1  one-cycle pulse: in_valid dropped because the block was busy.

Function
REQ-013 The block SHALL hold the previous sample (i_prev, q_prev) and a history-valid flag.
REQ-014 cross = i_prev*q_prompt - i_prompt*q_prev; dot = i_prev*i_prompt + q_prev*q_prompt; products 32-bit signed, sums 33-bit signed, no intermediate truncation.
REQ-015 One shared 16x16 signed multiplier SHALL be used, sequenced by FSM IDLE -> MUL0 -> MUL1 [-> MUL2 -> MUL3 if DOT_EN] -> OUT -> IDLE.
REQ-016 IDLE: in_valid captures current sample; if history invalid, sample is stored as history, history-valid set, no output, stay IDLE.
REQ-017 With history valid, in_valid latches the current sample and enters MUL0; one product accumulated per MUL state.
REQ-018 OUT: compute abs (|x| fits 32 bits unsigned), shift right OUT_SHIFT, saturate to 18'h3FFFF if any bit above 17 remains set, register outputs, pulse out_valid, copy current sample into history.
REQ-019 Latency: out_valid asserts exactly 3 cycles after in_valid (cross only) or 5 cycles (DOT_EN).
REQ-020 in_valid outside IDLE SHALL be dropped (history unchanged) and overrun pulsed the next cycle.
REQ-021 in_valid coincident with the OUT cycle is dropped (overrun pulsed); block accepts again from IDLE.
REQ-022 Output registers hold value between out_valid pulses.
REQ-023 cross_neg = 1 only for strictly negative cross; zero result gives mag 0, neg 0.

Reset
REQ-024 reset SHALL force IDLE, clear history-valid, i_prev/q_prev, all outputs, out_valid and overrun to 0 at the next edge, including mid-computation (partial result discarded, no out_valid).
REQ-025 First in_valid after reset is always a history-only capture.

Configuration
REQ-026 Macro FLL_DISC_DOT_EN defined: dot product computed, MUL2/MUL3 present, latency 5, dot_mag/dot_neg live.
REQ-027 Macro FLL_DISC_DOT_EN undefined: no dot logic, latency 3, dot_mag/dot_neg tied 0, ports kept.

Structure
REQ-028 Shared package fll_pkg: prompt width (16), magnitude width (18), FSM state encoding, saturation constant 18'h3FFFF.
REQ-029 Sub-module fll_abs_shift_sat (33-bit signed in, parameter OUT_SHIFT, 18-bit mag + sign out, combinational) instantiated per result.

Verification
REQ-030 Reset; in (1000,0) then (0,1000) -> no output after first; second: cross_mag=61, cross_neg=0, dot_mag=0, out_valid 3 cycles later (5 with DOT_EN).
REQ-031 Sequence (0,1000) then (1000,0) -> cross_mag=61, cross_neg=1.
REQ-032 (-32768,32767) then (-32768,-32768), OUT_SHIFT=14 -> cross_mag=131070, cross_neg=0; OUT_SHIFT=12 -> cross_mag=262143 (saturated).
REQ-033 Second in_valid 1 cycle after an accepted one -> overrun pulse, dropped sample absent from history, result matches first pair only.
REQ-034 Reset asserted in MUL1 -> no out_valid, outputs 0; next two samples behave as REQ-030.
